// File: rtl/cpu_stall_ctl.sv
// Pipeline interlock for the 5-stage core: load-use bubbles, fetch and
// data-memory wait stalls, and a latched bus-error state for stuck accesses.
module cpu_stall_ctl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       id_opcode,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic [4:0]       ex_rf_waddr,
   input  logic [1:0]       ex_c_wbsource,
   input  logic             imem_ready,
   input  logic             dmem_req,
   input  logic             dmem_ack,
   input  logic             err_clr,
   output logic             stall_pc,
   output logic             stall_if,
   output logic             bubble_id,
   output logic             stall_back,
   output logic             bus_err,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] perf_stall,
   output logic [CNT_W-1:0] perf_lduse
);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_MWAIT = 2'd1;
   localparam logic [1:0] ST_ERR   = 2'd2;

   localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);
   localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [1:0]       state_q, state_d;
   logic [WC_W-1:0]  wcnt_q, wcnt_d;
   logic [CNT_W-1:0] pstall_q, pstall_d;
   logic [CNT_W-1:0] plduse_q, plduse_d;

   logic uses_rt;
   logic lduse;
   logic mwait;
   logic lduse_hit;

   always_comb begin
      uses_rt = (id_opcode == 6'h00) || (id_opcode == 6'h04) ||
                (id_opcode == 6'h05) || (id_opcode == 6'h2b);
      lduse = (ex_c_wbsource == 2'h1) && (ex_rf_waddr != 5'd0) &&
              ((ex_rf_waddr == id_rs) ||
               (uses_rt && (ex_rf_waddr == id_rt)));
      mwait = dmem_req && !dmem_ack;
   end

   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      stall_pc   = 1'b0;
      stall_if   = 1'b0;
      bubble_id  = 1'b0;
      stall_back = 1'b0;
      lduse_hit  = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (mwait) begin
               stall_pc   = 1'b1;
               stall_if   = 1'b1;
               stall_back = 1'b1;
               state_d    = ST_MWAIT;
               wcnt_d     = WC_ONE;
            end else if (!imem_ready) begin
               stall_pc  = 1'b1;
               stall_if  = 1'b1;
               bubble_id = 1'b1;
            end else if (lduse) begin
               stall_pc  = 1'b1;
               stall_if  = 1'b1;
               bubble_id = 1'b1;
               lduse_hit = 1'b1;
            end
         end
         ST_MWAIT: begin
            stall_pc   = 1'b1;
            stall_if   = 1'b1;
            stall_back = 1'b1;
            // a dropped request is an aborted access, not a timeout
            if (dmem_ack || !dmem_req) begin
               state_d = ST_RUN;
               wcnt_d  = '0;
            end else if (wcnt_q == WC_LAST) begin
               state_d = ST_ERR;
            end else begin
               wcnt_d = wcnt_q + WC_ONE;
            end
         end
         ST_ERR: begin
            stall_pc   = 1'b1;
            stall_if   = 1'b1;
            stall_back = 1'b1;
            if (err_clr) begin
               state_d = ST_RUN;
               wcnt_d  = '0;
            end
         end
         default: begin
            state_d = ST_RUN;
            wcnt_d  = '0;
         end
      endcase
   end

   always_comb begin
      pstall_d = pstall_q;
      plduse_d = plduse_q;
      if (stall_pc && !(&pstall_q)) begin
         pstall_d = pstall_q + CNT_ONE;
      end
      if (lduse_hit && !(&plduse_q)) begin
         plduse_d = plduse_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_RUN;
         wcnt_q   <= '0;
         pstall_q <= '0;
         plduse_q <= '0;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         pstall_q <= pstall_d;
         plduse_q <= plduse_d;
      end
   end

   assign state      = state_q;
   assign bus_err    = (state_q == ST_ERR);
   assign perf_stall = pstall_q;
   assign perf_lduse = plduse_q;

endmodule
